// File: rtl/lzs_bit_packer_if.sv
// Code-in / word-out bundle between the LZS code generator, the packer and the write port.
// Latency: none (wires only).
// Backpressure: valid/ready on both the code side and the word side.
interface lzs_bit_packer_if #(
    parameter int CODE_W = 13,
    parameter int LEN_W  = 4,
    parameter int OUT_W  = 64
);
    localparam int NB_W = $clog2(OUT_W / 8) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic [LEN_W-1:0]  in_len;
    logic              in_fin;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic [NB_W-1:0]   out_nbytes;
    logic              done;

    // Environment view: produces codes, consumes words.
    modport master (
        output in_valid, in_code, in_len, in_fin, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_nbytes, done
    );

    // Packer view: consumes codes, produces words.
    modport slave (
        input  in_valid, in_code, in_len, in_fin, out_ready,
        output in_ready, out_valid, out_data, out_last, out_nbytes, done
    );
endinterface

// File: rtl/lzs_bit_packer.sv
// Packs right-aligned variable-length codes MSB-first into OUT_W-bit words; byte-pads and tags the last word.
// Latency: a code completing a word is accepted at edge N, the word is valid after edge N+1.
// Backpressure: in_ready drops when the output slot is held and a full word is already buffered.
// Build option: define PACK_BYTE_SWAP_EN to place stream byte 0 at out_data[7:0] (little-endian memory order).
module lzs_bit_packer #(
    parameter int CODE_W = 13,
    parameter int LEN_W  = 4,
    parameter int OUT_W  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    lzs_bit_packer_if.slave       bus
);
    localparam int ACC_W  = OUT_W + CODE_W - 1;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int NB_W   = $clog2(OUT_W / 8) + 1;
    localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);
    localparam logic [NB_W-1:0]   FULL_NB = NB_W'(OUT_W / 8);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_WAIT
    } state_t;

    state_t              state;
    logic [ACC_W-1:0]    acc;
    logic [FILL_W-1:0]   fill;

    logic                slot_free;
    logic                fill_ge;
    logic                word_move;
    logic                accept;
    logic [LEN_W-1:0]    len_s;
    logic [CODE_W-1:0]   code_mask;
    logic [ACC_W-1:0]    acc_next;
    logic [FILL_W-1:0]   fill_next;
    logic [OUT_W-1:0]    word_msb;
    logic [OUT_W-1:0]    tail_msb;
    logic [FILL_W:0]     fill_rnd;
    logic [NB_W-1:0]     tail_nb;

    // Reorders the MSB-first word into memory byte order for the selected build.
    function automatic logic [OUT_W-1:0] place(input logic [OUT_W-1:0] w);
        logic [OUT_W-1:0] r;
`ifdef PACK_BYTE_SWAP_EN
        for (int k = 0; k < OUT_W / 8; k++) begin
            r[8*k +: 8] = w[OUT_W-8-8*k +: 8];
        end
`else
        r = w;
`endif
        return r;
    endfunction

    assign len_s     = bus.in_len;
    assign slot_free = !bus.out_valid || bus.out_ready;
    assign fill_ge   = (fill >= OUT_W_F);
    assign word_move = slot_free && fill_ge && (state != ST_WAIT);

    // in_ready is combinational from out_ready so a draining slot admits a code in the same cycle.
    assign bus.in_ready = !rst && (state == ST_RUN) && (!fill_ge || slot_free);
    assign accept       = bus.in_valid && bus.in_ready;

    // Bits of the code above in_len are ignored.
    assign code_mask = ~({CODE_W{1'b1}} << len_s);
    assign acc_next  = (acc << len_s) | ACC_W'(bus.in_code & code_mask);

    // Oldest OUT_W valid bits sit at acc[fill-1 -: OUT_W]; the partial tail is left-justified,
    // bits above fill fall off the top and the low end fills with zeros.
    assign word_msb = OUT_W'(acc >> (fill - OUT_W_F));
    assign tail_msb = OUT_W'(acc << (OUT_W_F - fill));
    assign fill_rnd = {1'b0, fill} + (FILL_W + 1)'(7);
    assign tail_nb  = NB_W'(fill_rnd >> 3);

    // Fill bookkeeping: a word leaving and a code arriving may happen in the same cycle.
    always_comb begin
        fill_next = fill;
        if (word_move) begin
            fill_next = fill_next - OUT_W_F;
        end
        if (accept) begin
            fill_next = fill_next + FILL_W'(len_s);
        end
    end

    // Control FSM, accumulator and registered output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_RUN;
            acc            <= '0;
            fill           <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_last   <= 1'b0;
            bus.out_nbytes <= '0;
            bus.done       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end
            if (accept) begin
                acc <= acc_next;
            end
            fill <= fill_next;
            if (word_move) begin
                bus.out_valid  <= 1'b1;
                bus.out_data   <= place(word_msb);
                bus.out_last   <= 1'b0;
                bus.out_nbytes <= FULL_NB;
            end
            case (state)
                ST_RUN: begin
                    if (accept && bus.in_fin) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // Full words drain first; the sub-word tail (possibly empty) becomes the last word.
                    if (slot_free && !fill_ge) begin
                        bus.out_valid  <= 1'b1;
                        bus.out_data   <= place(tail_msb);
                        bus.out_last   <= 1'b1;
                        bus.out_nbytes <= tail_nb;
                        fill           <= '0;
                        acc            <= '0;
                        state          <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.out_valid && bus.out_ready && bus.out_last) begin
                        bus.done <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end
endmodule

// File: doc/lzs_bit_packer.md
# lzs_bit_packer

Parametrised variable-length code packer for the LZS encoder output path. It sits between the encoder's code generator and the memory/DMA write port. It accepts one right-aligned code of 0..CODE_W bits per cycle and packs codes MSB-first into OUT_W-bit words. It applies valid/ready backpressure in both directions, pads the stream to a byte boundary on finish, and tags the final word with a byte count.

## Interface
- CODE_W, 13, maximum code length in bits (1..OUT_W)
- LEN_W, 4, width of in_len; 2**LEN_W > CODE_W
- OUT_W, 64, output word width; multiple of 8, >= 16
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  code beat present
- in_ready  out  1  packer accepts beat this cycle
- in_code  in  CODE_W  code, right-aligned; bits above in_len ignored (masked)
- in_len  in  LEN_W  code length, 0..CODE_W; 0 = no bits (legal, used with in_fin)
- in_fin  in  1  qualifies beat as last of stream
- out_valid  out  1  word present
- out_ready  in  1  sink accepts word
- out_data  out  OUT_W  packed word
- out_last  out  1  final word of stream
- out_nbytes  out  clog2(OUT_W/8)+1  valid bytes in word; OUT_W/8 for non-last words
- done  out  1  one-cycle pulse after last word is accepted

## Operation
- Accumulator: ACC_W = OUT_W+CODE_W-1 bits, plus fill counter (0..ACC_W). A code appends left-to-right: acc = (acc << in_len) | masked code, fill += in_len.
- Output stage: one register (out_data/out_valid). It is free when !out_valid || out_ready.
- States:
  - RUN
    - in_ready = free-slot-or-fill<OUT_W.
    - When fill >= OUT_W and the slot is free, the top OUT_W bits move to out_data and fill -= OUT_W.
    - A beat with in_fin -> FLUSH.
  - FLUSH
    - in_ready = 0.
    - Full words drain as in RUN.
    - Once fill < OUT_W and the slot is free, the remaining bits load left-justified, zero-padded.
    - out_last=1, out_nbytes=ceil(fill/8) -> WAIT.
  - WAIT
    - in_ready = 0.
    - On out_valid & out_ready & out_last: done=1 for one cycle, fill=0 -> RUN.
- in_ready = (state==RUN) && (fill < OUT_W || slot free). This is a combinational path from out_ready.
- Simultaneous events:
  - A word moves out and a code is accepted in the same cycle: fill_next = fill - OUT_W + in_len.
- Empty finish: fill==0 in FLUSH still emits one last word: out_data=0, out_nbytes=0, out_last=1.
- in_len > CODE_W is illegal; behaviour is undefined, with no protection required.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, out_nbytes=0, done=0, in_ready=0 while rst=1. State=RUN, fill=0.
- in_ready=1 in the first cycle after rst deasserts.
- Latency: a code completing a word accepted at edge N gives out_valid=1 after edge N+1.
- Throughput: one code per cycle sustained while out_ready=1.
- out_data/out_last/out_nbytes hold stable while out_valid && !out_ready.
- Finish: after a fin beat at edge N with fill_after < OUT_W, out_last is valid after edge N+1. done pulses in the cycle after the last handshake.
- Reset mid-operation: any state, any pending word is dropped. Outputs return to reset values after the edge sampling rst=1.

## Configuration
- PACK_BYTE_SWAP_EN defined:
  - Stream byte k (k=0 first) is placed at out_data[8k+7:8k].
  - Little-endian memory order.
  - Bit order within each byte is unchanged (MSB first).
- Undefined:
  - Stream byte k is placed at out_data[OUT_W-1-8k : OUT_W-8-8k].
  - The first stream bit is out_data[OUT_W-1].
- out_nbytes and padding are identical in both builds. Padding is zeros in the unused high-index bytes (swap) or low-order bits (no swap).

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 -> all outputs 0, in_ready=0. First cycle after release -> in_ready=1, nothing accepted during reset.
- Eight codes, len 8, values 0x11,0x22..0x88, out_ready=1 -> one word, one cycle after the 8th accept. Expected 0x1122334455667788 without swap, 0x8877665544332211 with PACK_BYTE_SWAP_EN; out_nbytes=8, out_last=0.
- Five codes len 13, all ones, in_fin on the 5th -> word0=0xFFFFFFFFFFFFFFFF, then last word 0x8000000000000000 (no swap) with out_nbytes=1, out_last=1. Then done pulses once.
- Backpressure: random codes every cycle, out_ready low for 10 cycles -> in_ready drops, out_data stable. Reassembled bitstream matches the reference model bit-exact.
- Empty finish: in_valid, in_len=0, in_fin=1 at fill=0 -> single word out_data=0, out_nbytes=0, out_last=1, then done. in_ready=1 again after done.
- rst asserted while out_valid=1 in WAIT -> next cycle out_valid=0, out_last=0. A fresh stream of 8x8-bit codes then produces the correct first word.
